// File: rtl/keypad_entry_controller.sv
// Keypad entry sequencer: builds a BCD entry from key strobes with backspace, commit handshake
// and optional inactivity timeout (enabled by defining KEYPAD_ENTRY_TIMEOUT_EN).
module keypad_entry_controller #(
   parameter int MAX_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 250000000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [3:0]                         key_value,
   input  logic                               key_valid,
   output logic [4*MAX_DIGITS-1:0]            entry_bcd,
   output logic [$clog2(MAX_DIGITS+1)-1:0]    entry_count,
   output logic                               commit_valid,
   input  logic                               commit_ready,
   output logic [4*MAX_DIGITS-1:0]            commit_bcd,
   output logic [$clog2(MAX_DIGITS+1)-1:0]    commit_count,
   output logic                               err_pulse,
   output logic                               timeout_pulse
);

   localparam int BW = 4 * MAX_DIGITS;
   localparam int CW = $clog2(MAX_DIGITS + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ENTRY  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   if (MAX_DIGITS < 1 || MAX_DIGITS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("keypad_entry_controller: parameter out of legal range");
   end

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   logic [1:0]    state_r,        state_s;
   logic [BW-1:0] entry_bcd_r,    entry_bcd_s;
   logic [CW-1:0] entry_count_r,  entry_count_s;
   logic          commit_valid_r, commit_valid_s;
   logic [BW-1:0] commit_bcd_r,   commit_bcd_s;
   logic [CW-1:0] commit_count_r, commit_count_s;
   logic          err_r,          err_s;
   logic          timeout_r,      timeout_s;
   logic [BW-1:0] entry_shl_s;
   logic          expire_s;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] timer_r;

   assign expire_s = (state_r == ST_ENTRY) && (timer_r == TW'(TIMEOUT_CYCLES - 1));

   // Idle-cycle counter: runs only while in ENTRY and restarts on any key strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_r <= '0;
      end else if (key_valid || (state_r != ST_ENTRY) || expire_s) begin
         timer_r <= '0;
      end else begin
         timer_r <= timer_r + TW'(1);
      end
   end
`else
   assign expire_s = 1'b0;
`endif

   // Next-state and output computation for one key per cycle
   always_comb begin
      state_s        = state_r;
      entry_bcd_s    = entry_bcd_r;
      entry_count_s  = entry_count_r;
      commit_valid_s = commit_valid_r;
      commit_bcd_s   = commit_bcd_r;
      commit_count_s = commit_count_r;
      err_s          = 1'b0;
      timeout_s      = 1'b0;
      // Shift-in form works for MAX_DIGITS == 1 where a part-select would be empty
      entry_shl_s      = entry_bcd_r << 4;
      entry_shl_s[3:0] = key_value;

      case (state_r)
         ST_IDLE: begin
            if (key_valid) begin
               if (is_digit(key_value)) begin
                  entry_bcd_s   = BW'(key_value);
                  entry_count_s = CW'(1);
                  state_s       = ST_ENTRY;
               end else if (key_value == KEY_STAR) begin
                  state_s = ST_IDLE;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ENTRY: begin
            if (key_valid) begin
               if (is_digit(key_value)) begin
                  if (entry_count_r < CW'(MAX_DIGITS)) begin
                     entry_bcd_s   = entry_shl_s;
                     entry_count_s = entry_count_r + CW'(1);
                  end else begin
                     err_s = 1'b1;
                  end
               end else if (key_value == KEY_STAR) begin
                  if (entry_count_r > CW'(1)) begin
                     entry_bcd_s   = entry_bcd_r >> 4;
                     entry_count_s = entry_count_r - CW'(1);
                  end else begin
                     entry_bcd_s   = '0;
                     entry_count_s = '0;
                     state_s       = ST_IDLE;
                  end
               end else if (key_value == KEY_HASH) begin
                  commit_bcd_s   = entry_bcd_r;
                  commit_count_s = entry_count_r;
                  commit_valid_s = 1'b1;
                  entry_bcd_s    = '0;
                  entry_count_s  = '0;
                  state_s        = ST_COMMIT;
               end else begin
                  err_s = 1'b1;
               end
            end else if (expire_s) begin
               entry_bcd_s   = '0;
               entry_count_s = '0;
               timeout_s     = 1'b1;
               state_s       = ST_IDLE;
            end else begin
               state_s = ST_ENTRY;
            end
         end
         ST_COMMIT: begin
            err_s = key_valid;
            if (commit_ready) begin
               commit_valid_s = 1'b0;
               state_s        = ST_IDLE;
            end else begin
               state_s = ST_COMMIT;
            end
         end
         default: begin
            state_s        = ST_IDLE;
            entry_bcd_s    = '0;
            entry_count_s  = '0;
            commit_valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         entry_bcd_r    <= '0;
         entry_count_r  <= '0;
         commit_valid_r <= 1'b0;
         commit_bcd_r   <= '0;
         commit_count_r <= '0;
         err_r          <= 1'b0;
         timeout_r      <= 1'b0;
      end else begin
         state_r        <= state_s;
         entry_bcd_r    <= entry_bcd_s;
         entry_count_r  <= entry_count_s;
         commit_valid_r <= commit_valid_s;
         commit_bcd_r   <= commit_bcd_s;
         commit_count_r <= commit_count_s;
         err_r          <= err_s;
         timeout_r      <= timeout_s;
      end
   end

   assign entry_bcd     = entry_bcd_r;
   assign entry_count   = entry_count_r;
   assign commit_valid  = commit_valid_r;
   assign commit_bcd    = commit_bcd_r;
   assign commit_count  = commit_count_r;
   assign err_pulse     = err_r;
   assign timeout_pulse = timeout_r;

endmodule
